// File: rtl/semaforo_pkg.sv
// Shared types and decode helpers for the traffic-light monitor.
// LED vectors are packed as {red, yellow, green}.
package semaforo_pkg;

  typedef enum logic [1:0] {
    PH_RED    = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2,
    PH_UNK    = 2'd3
  } phase_e;

  // Encodings match phase_e so the phase output is the state itself.
  typedef enum logic [1:0] {
    StRed    = 2'd0,
    StGreen  = 2'd1,
    StYellow = 2'd2,
    StSync   = 2'd3
  } state_e;

  localparam logic [2:0] LedRed    = 3'b100;
  localparam logic [2:0] LedYellow = 3'b010;
  localparam logic [2:0] LedGreen  = 3'b001;

  function automatic phase_e next_phase(phase_e ph);
    phase_e res;
    case (ph)
      PH_RED:    res = PH_GREEN;
      PH_GREEN:  res = PH_YELLOW;
      PH_YELLOW: res = PH_RED;
      default:   res = PH_UNK;
    endcase
    return res;
  endfunction

  function automatic phase_e leds2phase(logic [2:0] leds);
    phase_e res;
    case (leds)
      LedRed:    res = PH_RED;
      LedGreen:  res = PH_GREEN;
      LedYellow: res = PH_YELLOW;
      default:   res = PH_UNK;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/semaforo_dwell_cnt.sv
// Saturating per-phase dwell counter with MIN/MAX window flags.
module semaforo_dwell_cnt #(
  parameter int unsigned DWELL_W   = 16,
  parameter int unsigned MIN_DWELL = 1,
  parameter int unsigned MAX_DWELL = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               load1,
  input  logic               inc,
  output logic [DWELL_W-1:0] value,
  output logic               below_min,
  output logic               above_max
);

  logic [DWELL_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load1) begin
      cnt_d = DWELL_W'(1);
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + DWELL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value     = cnt_q;
  assign below_min = (cnt_q < DWELL_W'(MIN_DWELL));
  // Set when one more clock in the same phase would exceed MAX_DWELL.
  assign above_max = (cnt_q >= DWELL_W'(MAX_DWELL));

endmodule

// File: rtl/semaforo_monitor.sv
// Passive checker for the traffic-light LEDs: phase tracking, order and
// dwell checks, cycle counting and sticky fault flags.
module semaforo_monitor
  import semaforo_pkg::*;
#(
  parameter int unsigned DWELL_W   = 16,
  parameter int unsigned MIN_DWELL = 1,
  parameter int unsigned MAX_DWELL = 1,
  parameter int unsigned CYC_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               green_led,
  input  logic               yellow_led,
  input  logic               red_led,
  input  logic               maint,
  input  logic               clr_faults,
  output logic [1:0]         phase,
  output logic               locked,
  output logic               fault_pattern,
  output logic               fault_seq,
  output logic               fault_dwell,
  output logic [CYC_W-1:0]   cycle_cnt,
  output logic [DWELL_W-1:0] last_dwell
);

  logic [2:0]         s_leds_q;
  state_e             state_q, state_d;
  logic               locked_q, locked_d;
  logic               checked_q, checked_d;
  logic               max_hit_q, max_hit_d;
  logic               fault_pat_q, fault_seq_q, fault_dwl_q;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [DWELL_W-1:0] last_q, last_d;

  logic               set_pat, set_seq, set_dwl;
  logic               dw_clr, dw_load, dw_inc;
  logic [DWELL_W-1:0] dw_value;
  logic               dw_below_min, dw_above_max;
  phase_e             cur_ph, st_ph;

  semaforo_dwell_cnt #(
    .DWELL_W   (DWELL_W),
    .MIN_DWELL (MIN_DWELL),
    .MAX_DWELL (MAX_DWELL)
  ) u_dwell (
    .clk       (clk),
    .rst       (rst),
    .clr       (dw_clr),
    .load1     (dw_load),
    .inc       (dw_inc),
    .value     (dw_value),
    .below_min (dw_below_min),
    .above_max (dw_above_max)
  );

  assign cur_ph = leds2phase(s_leds_q);
  assign st_ph  = phase_e'(state_q);

  always_comb begin
    state_d   = state_q;
    locked_d  = locked_q;
    checked_d = checked_q;
    max_hit_d = max_hit_q;
    cyc_d     = cyc_q;
    last_d    = last_q;
    set_pat   = 1'b0;
    set_seq   = 1'b0;
    set_dwl   = 1'b0;
    dw_clr    = 1'b0;
    dw_load   = 1'b0;
    dw_inc    = 1'b0;

    if (maint) begin
      state_d  = StSync;
      locked_d = 1'b0;
      dw_clr   = 1'b0 | 1'b1;
    end else begin
      unique case (state_q)
        StSync: begin
          if (cur_ph != PH_UNK) begin
            // First phase after a resync is partial: never MIN-checked.
            state_d   = state_e'(cur_ph);
            dw_load   = 1'b1;
            checked_d = 1'b0;
            max_hit_d = 1'b0;
          end else if (s_leds_q != 3'b000) begin
            set_pat = 1'b1;
          end
        end
        StRed, StGreen, StYellow: begin
          if (cur_ph == PH_UNK) begin
            set_pat  = 1'b1;
            state_d  = StSync;
            locked_d = 1'b0;
            dw_clr   = 1'b1;
          end else if (cur_ph == st_ph) begin
            dw_inc = 1'b1;
            if (dw_above_max && !max_hit_q) begin
              set_dwl   = 1'b1;
              max_hit_d = 1'b1;
            end
          end else if (cur_ph == next_phase(st_ph)) begin
            state_d   = state_e'(cur_ph);
            locked_d  = 1'b1;
            dw_load   = 1'b1;
            checked_d = 1'b1;
            max_hit_d = 1'b0;
            if (checked_q) begin
              last_d  = dw_value;
              set_dwl = dw_below_min;
            end
            if ((st_ph == PH_YELLOW) && locked_q) begin
              cyc_d = cyc_q + CYC_W'(1);
            end
          end else begin
            set_seq   = 1'b1;
            state_d   = state_e'(cur_ph);
            locked_d  = 1'b0;
            dw_load   = 1'b1;
            checked_d = 1'b0;
            max_hit_d = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_leds_q    <= 3'b000;
      state_q     <= StSync;
      locked_q    <= 1'b0;
      checked_q   <= 1'b0;
      max_hit_q   <= 1'b0;
      fault_pat_q <= 1'b0;
      fault_seq_q <= 1'b0;
      fault_dwl_q <= 1'b0;
      cyc_q       <= '0;
      last_q      <= '0;
    end else begin
      s_leds_q    <= {red_led, yellow_led, green_led};
      state_q     <= state_d;
      locked_q    <= locked_d;
      checked_q   <= checked_d;
      max_hit_q   <= max_hit_d;
      // A fault raised on the same edge as clr_faults wins.
      fault_pat_q <= (fault_pat_q & ~clr_faults) | set_pat;
      fault_seq_q <= (fault_seq_q & ~clr_faults) | set_seq;
      fault_dwl_q <= (fault_dwl_q & ~clr_faults) | set_dwl;
      cyc_q       <= cyc_d;
      last_q      <= last_d;
    end
  end

  assign phase         = st_ph;
  assign locked        = locked_q;
  assign fault_pattern = fault_pat_q;
  assign fault_seq     = fault_seq_q;
  assign fault_dwell   = fault_dwl_q;
  assign cycle_cnt     = cyc_q;
  assign last_dwell    = last_q;

endmodule

// File: tb/tb_semaforo_monitor.sv
// Scoreboard bench: two monitor instances (default and narrow/strict params)
// checked every clock against a behavioural model of the light rules.
module tb_semaforo_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic green_led = 1'b0, yellow_led = 1'b0, red_led = 1'b0;
  logic maint = 1'b0, clr_faults = 1'b0;

  logic [1:0]  phase_a, phase_b;
  logic        locked_a, locked_b;
  logic        fp_a, fs_a, fd_a, fp_b, fs_b, fd_b;
  logic [15:0] cyc_a, last_a;
  logic [3:0]  cyc_b;
  logic [2:0]  last_b;

  always #5 clk = ~clk;

  semaforo_monitor dut_a (
    .clk (clk), .rst (rst), .green_led (green_led), .yellow_led (yellow_led),
    .red_led (red_led), .maint (maint), .clr_faults (clr_faults),
    .phase (phase_a), .locked (locked_a), .fault_pattern (fp_a), .fault_seq (fs_a),
    .fault_dwell (fd_a), .cycle_cnt (cyc_a), .last_dwell (last_a)
  );

  semaforo_monitor #(
    .DWELL_W (3), .MIN_DWELL (2), .MAX_DWELL (5), .CYC_W (4)
  ) dut_b (
    .clk (clk), .rst (rst), .green_led (green_led), .yellow_led (yellow_led),
    .red_led (red_led), .maint (maint), .clr_faults (clr_faults),
    .phase (phase_b), .locked (locked_b), .fault_pattern (fp_b), .fault_seq (fs_b),
    .fault_dwell (fd_b), .cycle_cnt (cyc_b), .last_dwell (last_b)
  );

  logic [37:0] act_a, act_b;
  assign act_a = {phase_a, locked_a, fp_a, fs_a, fd_a, cyc_a, last_a};
  assign act_b = {phase_b, locked_b, fp_b, fs_b, fd_b, 12'd0, cyc_b, 13'd0, last_b};

  // Reference model: phases as 0=red 1=green 2=yellow 3=none; red->green->yellow is +1 mod 3.
  typedef struct {
    int       ph;
    int       dwell;
    bit       locked;
    bit       partial;
    bit       max_flag;
    bit       fp, fs, fd;
    int       cyc;
    int       last;
    logic [2:0] sleds;
  } model_t;

  model_t ma, mb;
  logic [37:0] exp_a[$], exp_b[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic model_t model_reset();
    model_t m;
    m.ph = 3; m.dwell = 0; m.locked = 0; m.partial = 1; m.max_flag = 0;
    m.fp = 0; m.fs = 0; m.fd = 0; m.cyc = 0; m.last = 0; m.sleds = 3'b000;
    return m;
  endfunction

  // LED vector is {red, yellow, green}.
  function automatic int seen_phase(logic [2:0] l);
    if ($countones(l) != 1) return 3;
    if (l[2]) return 0;
    if (l[0]) return 1;
    return 2;
  endfunction

  function automatic logic [2:0] lamp(int k);
    logic [2:0] l;
    l = 3'b000;
    if (k == 0) l = 3'b100;
    else if (k == 1) l = 3'b001;
    else if (k == 2) l = 3'b010;
    return l;
  endfunction

  function automatic model_t model_step(model_t m, bit r, logic [2:0] leds, bit mt, bit clr,
                                        int dw_bits, int min_d, int max_d, int cyc_bits);
    model_t n;
    int seen;
    bit sp, ss, sd;
    if (r) return model_reset();
    n = m; sp = 0; ss = 0; sd = 0;
    seen = seen_phase(m.sleds);
    if (mt) begin
      n.ph = 3; n.dwell = 0; n.locked = 0;
    end else if (m.ph == 3) begin
      if (seen != 3) begin
        n.ph = seen; n.dwell = 1; n.partial = 1; n.max_flag = 0;
      end else if ($countones(m.sleds) > 1) begin
        sp = 1;
      end
    end else if (seen == 3) begin
      sp = 1; n.ph = 3; n.locked = 0; n.dwell = 0;
    end else if (seen == m.ph) begin
      n.dwell = (m.dwell + 1 > (1 << dw_bits) - 1) ? m.dwell : m.dwell + 1;
      if (m.dwell + 1 > max_d && !m.max_flag) begin
        sd = 1; n.max_flag = 1;
      end
    end else if (seen == (m.ph + 1) % 3) begin
      n.ph = seen; n.locked = 1; n.dwell = 1; n.partial = 0; n.max_flag = 0;
      if (!m.partial) begin
        n.last = m.dwell;
        if (m.dwell < min_d) sd = 1;
      end
      if (m.ph == 2 && m.locked) n.cyc = (m.cyc + 1) % (1 << cyc_bits);
    end else begin
      ss = 1; n.ph = seen; n.locked = 0; n.dwell = 1; n.partial = 1; n.max_flag = 0;
    end
    n.fp = (m.fp && !clr) || sp;
    n.fs = (m.fs && !clr) || ss;
    n.fd = (m.fd && !clr) || sd;
    n.sleds = leds;
    return n;
  endfunction

  function automatic logic [37:0] pack(model_t m);
    return {2'(m.ph), m.locked, m.fp, m.fs, m.fd, 16'(m.cyc), 16'(m.last)};
  endfunction

  task automatic drive(input bit r, input logic [2:0] leds, input bit mt, input bit clr);
    @(negedge clk);
    rst = r;
    {red_led, yellow_led, green_led} = leds;
    maint = mt;
    clr_faults = clr;
    ma = model_step(ma, r, leds, mt, clr, 16, 1, 1, 16);
    mb = model_step(mb, r, leds, mt, clr, 3, 2, 5, 4);
    exp_a.push_back(pack(ma));
    exp_b.push_back(pack(mb));
  endtask

  task automatic check(input string nm, input logic [37:0] exp, input logic [37:0] act);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got phase=%b locked=%b faults(p,s,d)=%b%b%b cyc=%0d last=%0d; need phase=%b locked=%b faults(p,s,d)=%b%b%b cyc=%0d last=%0d",
               nm, $time, act[37:36], act[35], act[34], act[33], act[32], act[31:16], act[15:0],
               exp[37:36], exp[35], exp[34], exp[33], exp[32], exp[31:16], exp[15:0]);
    end
  endtask

  // Monitor: the DUT presents a fresh output set after every edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_a.size() > 0) check("dut_a outputs", exp_a.pop_front(), act_a);
      if (exp_b.size() > 0) check("dut_b outputs", exp_b.pop_front(), act_b);
    end
  end

  initial begin
    int ctl_ph;
    int ctl_left;
    bit mt;
    ma = model_reset();
    mb = model_reset();
    drive(1, 3'b000, 0, 0);
    drive(1, 3'b000, 0, 0);
    // Controller's nominal sequence, one clock per lamp, ten cycles.
    for (int i = 0; i < 10; i++) begin
      drive(0, lamp(0), 0, 0);
      drive(0, lamp(1), 0, 0);
      drive(0, lamp(2), 0, 0);
    end
    drive(0, lamp(0), 0, 0);
    // Green held three clocks, then a clear pulse.
    for (int i = 0; i < 3; i++) drive(0, lamp(1), 0, 0);
    drive(0, lamp(2), 0, 0);
    drive(0, lamp(0), 0, 0);
    drive(0, lamp(0), 0, 1);
    drive(0, lamp(1), 0, 0);
    drive(0, lamp(2), 0, 0);
    // Red then yellow, skipping green.
    drive(0, lamp(0), 0, 0);
    drive(0, lamp(2), 0, 0);
    drive(0, lamp(2), 0, 0);
    // Red+green together, then relock.
    drive(0, 3'b101, 0, 0);
    drive(0, lamp(0), 0, 0);
    drive(0, lamp(1), 0, 0);
    drive(0, lamp(2), 0, 0);
    drive(0, lamp(0), 0, 0);
    // Maintenance with arbitrary patterns, then resync.
    for (int i = 0; i < 20; i++) drive(0, 3'($urandom_range(0, 7)), 1, 0);
    for (int i = 0; i < 7; i++) drive(0, lamp(i % 3), 0, 0);
    // Reset mid-yellow while a pattern fault and a clear are pending.
    drive(0, lamp(1), 0, 0);
    drive(0, lamp(2), 0, 0);
    drive(0, 3'b111, 0, 0);
    drive(1, 3'b111, 1, 1);
    drive(0, lamp(0), 0, 0);
    drive(0, lamp(1), 0, 0);
    // Randomized controller with glitches, skips, maint bursts, clears and resets.
    ctl_ph = 0;
    ctl_left = 1;
    mt = 0;
    for (int i = 0; i < 700; i++) begin
      int r;
      logic [2:0] leds;
      r = $urandom_range(0, 99);
      if (ctl_left == 0) begin
        ctl_ph = (ctl_ph + 1) % 3;
        ctl_left = $urandom_range(1, 10);
      end
      ctl_left--;
      leds = lamp(ctl_ph);
      if (r < 5) leds = 3'($urandom_range(0, 7));
      else if (r < 8) leds = lamp((ctl_ph + 2) % 3);
      if ($urandom_range(0, 99) < 2) mt = !mt;
      drive($urandom_range(0, 299) == 0, leds, mt, $urandom_range(0, 99) < 5);
    end
    drive(0, 3'b000, 0, 0);
    @(posedge clk);
    #2;
    n_cmp++;
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d/%0d expected entries left, need 0/0", exp_a.size(), exp_b.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
